// File: rtl/data_bus_responder.sv
// Data-bus responder for the single-cycle core: word RAM plus a GPIO/timer/fault MMIO block.
// Reads are combinational with zero latency. Writes commit at the next rising edge. The bus has no backpressure.
module data_bus_responder #(
   parameter int unsigned RAM_WORDS = 64,
   parameter logic [31:0] MMIO_BASE = 32'h0000_1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [31:0] GpioOut,
   output logic        TimerIrq,
   output logic        Fault
);

   localparam int unsigned AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
   localparam logic [31:0] MMIO_SPAN = 32'h0000_0014;

   localparam logic [2:0] REG_GPIO   = 3'd0;
   localparam logic [2:0] REG_COUNT  = 3'd1;
   localparam logic [2:0] REG_CMP    = 3'd2;
   localparam logic [2:0] REG_STATUS = 3'd3;
   localparam logic [2:0] REG_FADDR  = 3'd4;

   logic [31:0] ram [RAM_WORDS];

   logic [31:0] gpio_q;
   logic [31:0] count_q;
   logic [31:0] cmp_q;
   logic [31:0] fault_addr_q;
   logic        match_q;
   logic        en_q;
   logic        fault_q;
   logic        irq_en_q;

   logic          misaligned;
   logic          ram_hit;
   logic          mmio_hit;
   logic          bad_access;
   logic [31:0]   mmio_off;
   logic [2:0]    reg_idx;
   logic [AW-1:0] ram_idx;

   logic wr_ok;
   logic ram_we;
   logic mmio_we;
   logic wr_gpio;
   logic wr_count;
   logic wr_cmp;
   logic wr_status;
   logic count_eq;
   logic match_set;

   // Address decode; RAM wins if a parameter choice ever makes the windows overlap.
   assign misaligned = (DataAdr[1:0] != 2'b00);
   assign ram_hit    = (DataAdr < RAM_BYTES);
   assign mmio_off   = DataAdr - MMIO_BASE;
   assign mmio_hit   = (DataAdr >= MMIO_BASE) && (mmio_off < MMIO_SPAN);
   assign bad_access = misaligned | ~(ram_hit | mmio_hit);
   assign reg_idx    = mmio_off[4:2];
   assign ram_idx    = DataAdr[AW+1:2];

   // A faulting write is dropped entirely, including any W1C it would have carried.
   assign wr_ok     = MemWrite & ~bad_access;
   assign ram_we    = wr_ok & ram_hit;
   assign mmio_we   = wr_ok & ~ram_hit & mmio_hit;
   assign wr_gpio   = mmio_we & (reg_idx == REG_GPIO);
   assign wr_count  = mmio_we & (reg_idx == REG_COUNT);
   assign wr_cmp    = mmio_we & (reg_idx == REG_CMP);
   assign wr_status = mmio_we & (reg_idx == REG_STATUS);

   assign count_eq  = (count_q == cmp_q);
   assign match_set = en_q & count_eq & ~wr_count;

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_idx] <= WriteData;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gpio_q       <= '0;
         count_q      <= '0;
         cmp_q        <= '0;
         fault_addr_q <= '0;
         match_q      <= 1'b0;
         en_q         <= 1'b0;
         fault_q      <= 1'b0;
         irq_en_q     <= 1'b0;
      end else begin
         if (wr_gpio) begin
            gpio_q <= WriteData;
         end
         if (wr_cmp) begin
            cmp_q <= WriteData;
         end

         if (wr_count) begin
            count_q <= WriteData;
         end else if (en_q) begin
            count_q <= count_eq ? '0 : count_q + 32'd1;
         end

         // Sticky flags: a new event in the same cycle beats the W1C.
         if (match_set) begin
            match_q <= 1'b1;
         end else if (wr_status && WriteData[0]) begin
            match_q <= 1'b0;
         end

         if (wr_status) begin
            en_q     <= WriteData[1];
            irq_en_q <= WriteData[3];
         end

         if (bad_access) begin
            fault_q      <= 1'b1;
            fault_addr_q <= DataAdr;
         end else if (wr_status && WriteData[2]) begin
            fault_q <= 1'b0;
         end
      end
   end

   always_comb begin
      ReadData = '0;
      if (!bad_access) begin
         if (ram_hit) begin
            ReadData = ram[ram_idx];
         end else begin
            case (reg_idx)
               REG_GPIO:   ReadData = gpio_q;
               REG_COUNT:  ReadData = count_q;
               REG_CMP:    ReadData = cmp_q;
               REG_STATUS: ReadData = {28'd0, irq_en_q, fault_q, en_q, match_q};
               REG_FADDR:  ReadData = fault_addr_q;
               default:    ReadData = '0;
            endcase
         end
      end
   end

   assign GpioOut  = gpio_q;
   assign TimerIrq = match_q & irq_en_q;
   assign Fault    = fault_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: RAM, GPIO, timer, fault capture and set-wins corner cases.
module tb_data_bus_responder;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [31:0] GpioOut;
   logic        TimerIrq;
   logic        Fault;

   int n_checks;
   int n_pass;

   localparam logic [31:0] A_GPIO   = 32'h0000_1000;
   localparam logic [31:0] A_COUNT  = 32'h0000_1004;
   localparam logic [31:0] A_CMP    = 32'h0000_1008;
   localparam logic [31:0] A_STATUS = 32'h0000_100C;
   localparam logic [31:0] A_FADDR  = 32'h0000_1010;

   data_bus_responder dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .DataAdr   (DataAdr),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .GpioOut   (GpioOut),
      .TimerIrq  (TimerIrq),
      .Fault     (Fault)
   );

   always #5 clk = ~clk;

   // One write cycle; leaves inputs just after the committing edge.
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      DataAdr   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      @(posedge clk);
      #1;
      MemWrite  = 1'b0;
      WriteData = '0;
   endtask

   // Present an address with no write and let one edge pass.
   task automatic step_at(input logic [31:0] a);
      DataAdr  = a;
      MemWrite = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Combinational read, no clock edge.
   task automatic rd(input logic [31:0] a);
      DataAdr  = a;
      MemWrite = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (GpioOut !== 32'h0) $display("FAIL rst_gpio: got %h expected %h", GpioOut, 32'h0); else n_pass++;
      n_checks++; if (TimerIrq !== 1'b0) $display("FAIL rst_irq: got %b expected 0", TimerIrq); else n_pass++;
      n_checks++; if (Fault !== 1'b0) $display("FAIL rst_fault: got %b expected 0", Fault); else n_pass++;
      rd(A_STATUS);
      n_checks++; if (ReadData !== 32'h0) $display("FAIL rst_status: got %h expected %h", ReadData, 32'h0); else n_pass++;
      rd(A_COUNT);
      n_checks++; if (ReadData !== 32'h0) $display("FAIL rst_count: got %h expected %h", ReadData, 32'h0); else n_pass++;
      reset = 1'b0;
      step_at(A_COUNT);
   endtask

   task automatic test_ram;
      bus_write(32'h14, 32'h0);
      bus_write(32'h10, 32'hDEAD_BEEF);
      rd(32'h10);
      n_checks++; if (ReadData !== 32'hDEAD_BEEF) $display("FAIL ram_rd10: got %h expected %h", ReadData, 32'hDEAD_BEEF); else n_pass++;
      rd(32'h14);
      n_checks++; if (ReadData !== 32'h0) $display("FAIL ram_rd14: got %h expected %h", ReadData, 32'h0); else n_pass++;
      bus_write(32'hFC, 32'h1357_9BDF);
      rd(32'hFC);
      n_checks++; if (ReadData !== 32'h1357_9BDF) $display("FAIL ram_top: got %h expected %h", ReadData, 32'h1357_9BDF); else n_pass++;
      rd(32'h100);
      n_checks++; if (ReadData !== 32'h0) $display("FAIL ram_past_end_rd: got %h expected %h", ReadData, 32'h0); else n_pass++;
      step_at(32'h100);
      n_checks++; if (Fault !== 1'b1) $display("FAIL ram_past_end_fault: got %b expected 1", Fault); else n_pass++;
      rd(A_FADDR);
      n_checks++; if (ReadData !== 32'h100) $display("FAIL ram_past_end_faddr: got %h expected %h", ReadData, 32'h100); else n_pass++;
   endtask

   task automatic test_gpio;
      bus_write(A_GPIO, 32'h0000_00A5);
      n_checks++; if (GpioOut !== 32'hA5) $display("FAIL gpio_out: got %h expected %h", GpioOut, 32'hA5); else n_pass++;
      rd(A_GPIO);
      n_checks++; if (ReadData !== 32'hA5) $display("FAIL gpio_rd: got %h expected %h", ReadData, 32'hA5); else n_pass++;
      reset = 1'b1;
      #1;
      n_checks++; if (GpioOut !== 32'h0) $display("FAIL gpio_async_rst: got %h expected %h", GpioOut, 32'h0); else n_pass++;
      n_checks++; if (Fault !== 1'b0) $display("FAIL fault_async_rst: got %b expected 0", Fault); else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      step_at(A_COUNT);
   endtask

   task automatic test_timer_match;
      bus_write(A_CMP, 32'd3);
      bus_write(A_STATUS, 32'hA);
      rd(A_COUNT);
      n_checks++; if (ReadData !== 32'd0) $display("FAIL tmr_c0: got %h expected %h", ReadData, 32'd0); else n_pass++;
      step_at(A_COUNT);
      n_checks++; if (ReadData !== 32'd1) $display("FAIL tmr_c1: got %h expected %h", ReadData, 32'd1); else n_pass++;
      step_at(A_COUNT);
      n_checks++; if (ReadData !== 32'd2) $display("FAIL tmr_c2: got %h expected %h", ReadData, 32'd2); else n_pass++;
      step_at(A_COUNT);
      n_checks++; if (ReadData !== 32'd3) $display("FAIL tmr_c3: got %h expected %h", ReadData, 32'd3); else n_pass++;
      n_checks++; if (TimerIrq !== 1'b0) $display("FAIL tmr_irq_early: got %b expected 0", TimerIrq); else n_pass++;
      step_at(A_COUNT);
      n_checks++; if (ReadData !== 32'd0) $display("FAIL tmr_wrap_cmp: got %h expected %h", ReadData, 32'd0); else n_pass++;
      n_checks++; if (TimerIrq !== 1'b1) $display("FAIL tmr_irq_set: got %b expected 1", TimerIrq); else n_pass++;
      rd(A_STATUS);
      n_checks++; if (ReadData !== 32'hB) $display("FAIL tmr_status: got %h expected %h", ReadData, 32'hB); else n_pass++;
      bus_write(A_STATUS, 32'hB);
      n_checks++; if (TimerIrq !== 1'b0) $display("FAIL tmr_irq_clr: got %b expected 0", TimerIrq); else n_pass++;
      step_at(A_COUNT);
      step_at(A_COUNT);
      n_checks++; if (TimerIrq !== 1'b0) $display("FAIL tmr_irq_quiet: got %b expected 0", TimerIrq); else n_pass++;
      step_at(A_COUNT);
      n_checks++; if (TimerIrq !== 1'b1) $display("FAIL tmr_irq_again: got %b expected 1", TimerIrq); else n_pass++;
   endtask

   task automatic test_count_load;
      bus_write(A_STATUS, 32'h9);
      bus_write(A_CMP, 32'd5);
      bus_write(A_COUNT, 32'd5);
      bus_write(A_STATUS, 32'hA);
      bus_write(A_COUNT, 32'h100);
      rd(A_COUNT);
      n_checks++; if (ReadData !== 32'h100) $display("FAIL load_count: got %h expected %h", ReadData, 32'h100); else n_pass++;
      rd(A_STATUS);
      n_checks++; if (ReadData !== 32'hA) $display("FAIL load_no_match: got %h expected %h", ReadData, 32'hA); else n_pass++;
      bus_write(A_STATUS, 32'h8);
      bus_write(A_CMP, 32'd0);
      bus_write(A_COUNT, 32'hFFFF_FFFF);
      bus_write(A_STATUS, 32'hA);
      rd(A_COUNT);
      n_checks++; if (ReadData !== 32'hFFFF_FFFF) $display("FAIL wrap_frozen: got %h expected %h", ReadData, 32'hFFFF_FFFF); else n_pass++;
      step_at(A_COUNT);
      n_checks++; if (ReadData !== 32'd0) $display("FAIL wrap_to0: got %h expected %h", ReadData, 32'd0); else n_pass++;
      n_checks++; if (TimerIrq !== 1'b0) $display("FAIL wrap_no_irq: got %b expected 0", TimerIrq); else n_pass++;
      step_at(A_COUNT);
      n_checks++; if (TimerIrq !== 1'b1) $display("FAIL wrap_then_match: got %b expected 1", TimerIrq); else n_pass++;
      rd(A_STATUS);
      n_checks++; if (ReadData !== 32'hB) $display("FAIL wrap_status: got %h expected %h", ReadData, 32'hB); else n_pass++;
   endtask

   task automatic test_faults;
      n_checks++; if (Fault !== 1'b0) $display("FAIL flt_clean: got %b expected 0", Fault); else n_pass++;
      rd(32'h12);
      n_checks++; if (ReadData !== 32'h0) $display("FAIL flt_misaligned_rd: got %h expected %h", ReadData, 32'h0); else n_pass++;
      bus_write(32'h12, 32'h1234);
      n_checks++; if (Fault !== 1'b1) $display("FAIL flt_set: got %b expected 1", Fault); else n_pass++;
      rd(32'h10);
      n_checks++; if (ReadData !== 32'hDEAD_BEEF) $display("FAIL flt_ram_kept: got %h expected %h", ReadData, 32'hDEAD_BEEF); else n_pass++;
      rd(A_FADDR);
      n_checks++; if (ReadData !== 32'h12) $display("FAIL flt_addr12: got %h expected %h", ReadData, 32'h12); else n_pass++;
      rd(32'h8000);
      n_checks++; if (ReadData !== 32'h0) $display("FAIL flt_unmapped_rd: got %h expected %h", ReadData, 32'h0); else n_pass++;
      step_at(32'h8000);
      rd(A_FADDR);
      n_checks++; if (ReadData !== 32'h8000) $display("FAIL flt_addr8000: got %h expected %h", ReadData, 32'h8000); else n_pass++;
      bus_write(A_FADDR, 32'hFFFF);
      rd(A_FADDR);
      n_checks++; if (ReadData !== 32'h8000) $display("FAIL flt_addr_ro: got %h expected %h", ReadData, 32'h8000); else n_pass++;
      bus_write(A_STATUS, 32'h4);
      n_checks++; if (Fault !== 1'b0) $display("FAIL flt_w1c: got %b expected 0", Fault); else n_pass++;
   endtask

   task automatic test_set_wins;
      bus_write(A_STATUS, 32'h1);
      rd(A_STATUS);
      n_checks++; if (ReadData !== 32'h0) $display("FAIL sw_cleared: got %h expected %h", ReadData, 32'h0); else n_pass++;
      bus_write(A_CMP, 32'd2);
      bus_write(A_COUNT, 32'd2);
      bus_write(A_STATUS, 32'h2);
      rd(A_COUNT);
      n_checks++; if (ReadData !== 32'd2) $display("FAIL sw_count_pre: got %h expected %h", ReadData, 32'd2); else n_pass++;
      bus_write(A_STATUS, 32'h3);
      rd(A_STATUS);
      n_checks++; if (ReadData !== 32'h3) $display("FAIL sw_match_kept: got %h expected %h", ReadData, 32'h3); else n_pass++;
      rd(A_COUNT);
      n_checks++; if (ReadData !== 32'd0) $display("FAIL sw_count_post: got %h expected %h", ReadData, 32'd0); else n_pass++;
      n_checks++; if (TimerIrq !== 1'b0) $display("FAIL sw_irq_gated: got %b expected 0", TimerIrq); else n_pass++;
   endtask

   initial begin
      clk       = 1'b0;
      reset     = 1'b0;
      MemWrite  = 1'b0;
      DataAdr   = A_COUNT;
      WriteData = '0;
      n_checks  = 0;
      n_pass    = 0;
      #2;
      test_reset();
      test_ram();
      test_gpio();
      test_timer_match();
      test_count_load();
      test_faults();
      test_set_wins();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
Responder end of the single-cycle core's data bus: services the core's MemWrite/address/WriteData requests and returns ReadData in the same cycle. Contains a word-addressed data RAM plus a small MMIO register block: GPIO output latch, free-running timer with compare/match interrupt, and a fault-capture register. Sits beside the processor top in the system wrapper, replacing a bare data memory.

Parameters:
RAM_WORDS, 64, number of 32-bit RAM words; RAM occupies byte addresses 0 .. 4*RAM_WORDS-1.
MMIO_BASE, 32'h0000_1000, byte base address of the MMIO register block.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
MemWrite  input  1  write strobe from core; write commits at next rising edge
DataAdr  input  32  byte address from core (ALU result)
WriteData  input  32  write data from core
ReadData  output  32  combinational read data for DataAdr
GpioOut  output  32  GPIO output register value
TimerIrq  output  1  timer interrupt, level
Fault  output  1  sticky bus-fault flag (STATUS bit2)

Behaviour:
- Access rules: word accesses only. DataAdr[1:0] != 0 is misaligned. An address outside RAM and outside MMIO_BASE..MMIO_BASE+0x13 is unmapped.
- Reads: ReadData is purely combinational from DataAdr and current state, with zero latency. Misaligned, unmapped and MemWrite=1 cycles still drive read data; misaligned/unmapped reads return 0.
- RAM: synchronous write when MemWrite=1 and address maps to RAM. RAM contents are not reset.
- MMIO map, offsets from MMIO_BASE:
  - 0x00 GPIO_OUT: RW; drives GpioOut.
  - 0x04 TIMER_COUNT: RW; a write loads the count.
  - 0x08 TIMER_CMP: RW.
  - 0x0C STATUS:
    - bit0 MATCH: W1C.
    - bit1 EN: RW.
    - bit2 FAULT: W1C.
    - bit3 IRQ_EN: RW.
    - bits31:4 read 0, writes ignored.
  - 0x10 FAULT_ADDR: RO; writes ignored.
- Reset: all MMIO registers are 0 (GPIO_OUT, COUNT, CMP, STATUS, FAULT_ADDR). GpioOut=0, TimerIrq=0, Fault=0.
- Timer, per edge:
  - If a TIMER_COUNT write occurs, COUNT <= WriteData. The write beats any increment or wrap.
  - Else if EN=1 and COUNT==CMP, COUNT <= 0 and MATCH is set.
  - Else if EN=1, COUNT <= COUNT+1, modulo 2^32 (0xFFFF_FFFF wraps to 0 and does not set MATCH unless CMP matches).
  - EN=0 freezes COUNT.
- MATCH set/clear: when a W1C to bit0 and a new match occur in the same cycle, set wins.
- TimerIrq = MATCH & IRQ_EN, combinational from registers.
- Fault capture: on any access (read or write) that is misaligned or unmapped, FAULT <= 1 and FAULT_ADDR <= DataAdr at the edge.
  - FAULT_ADDR is overwritten by each later fault.
  - A faulting write changes no other state.
  - A W1C to FAULT in the same cycle as a new fault: set wins.
  - Fault = FAULT.
- STATUS write: EN and IRQ_EN take WriteData bits; bit0/bit2 of WriteData=1 clear the corresponding flag, subject to the set-wins rules above.
- Reset asserted mid-operation immediately clears all MMIO state, asynchronously. After release, the first edge behaves as after power-up.

Test Plan:
- RAM write/readback: write 0xDEADBEEF to 0x0000_0010; next cycle read 0x10 -> ReadData=0xDEADBEEF. Read 0x14, never written after reset-time write of 0 -> 0x0000_0000.
- GPIO: write 0x0000_00A5 to 0x1000 -> GpioOut=0xA5 after the edge; read 0x1000 returns 0xA5. Assert reset -> GpioOut=0 immediately, without waiting for a clock.
- Timer match: write CMP=3, STATUS=0xA (EN, IRQ_EN) -> COUNT goes 0,1,2,3, then 0 with MATCH=1 and TimerIrq=1. Write STATUS=0xB (W1C bit0, keep EN/IRQ_EN) -> TimerIrq=0; the next match sets it again after 4 more cycles.
- Count load priority: EN=1, COUNT==CMP=5, write COUNT=0x100 in that cycle -> COUNT=0x100 and MATCH not set. COUNT=0xFFFF_FFFF, CMP=0 -> wraps to 0, then next edge sets MATCH.
- Faults: write 0x1234 to 0x0000_0012 -> RAM unchanged, Fault=1, FAULT_ADDR=0x12, read returns 0. Then read 0x0000_8000 -> FAULT_ADDR=0x8000. Write STATUS bit2=1 -> Fault=0.
- Simultaneous set/clear: W1C MATCH in the same cycle COUNT==CMP with EN=1 -> MATCH remains 1.
